// File: rtl/countdown_timer.sv
// ============================================================================
// countdown_timer
// ----------------------------------------------------------------------------
// Four-digit BCD countdown timer for the alarm clock. It is loaded from the
// set-time digits, counts down towards 0000 on accepted tick strobes while
// running, and raises an alarm when the count reaches zero.
//
// Optional build macro:
//   COUNTDOWN_AUTO_RELOAD_EN
//     When defined, reaching zero while running with a non-zero reload value
//     reloads the count, keeps running and pulses alarm for one cycle.
//     A reload value of 0000 still ends in DONE with alarm latched.
//
// Parameters:
//   PRESCALE   accepted ticks per decrement, 1..255
//
// Ports:
//   reloj       in   system clock, rising edge
//   reseteador  in   synchronous active-high reset
//   tick        in   one-cycle count strobe (only counted while running)
//   load        in   capture d0..d3 as the new count and reload value
//   d0..d3      in   BCD digits to load (units..thousands), clamped to 9
//   start       in   begin or resume counting
//   stop        in   pause counting
//   ack         in   acknowledge and clear a latched alarm
//   b0..b3      out  current count (units..thousands)
//   running     out  high while in RUN
//   alarm       out  zero-reached indication
// ============================================================================
module countdown_timer #(
    parameter int PRESCALE = 1
) (
    input  logic       reloj,
    input  logic       reseteador,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [3:0] b0,
    output logic [3:0] b1,
    output logic [3:0] b2,
    output logic [3:0] b3,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Prescale counter value on which the next accepted tick decrements.
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t          state_reg, state_next;
    logic [3:0][3:0] cnt_reg, cnt_next;
    logic [3:0][3:0] reload_reg, reload_next;
    logic [7:0]      presc_reg, presc_next;
    logic            alarm_reg, alarm_next;
    logic            running_reg, running_next;

    // ------------------------------------------------------------------
    // Digit-wise helpers: load clamping and BCD decrement with borrow.
    // ------------------------------------------------------------------
    logic [3:0][3:0] din;
    logic [3:0][3:0] din_clamped;
    logic [3:0][3:0] cnt_dec;
    logic [3:0]      borrow;    // borrow[i]: digit i must decrement
    logic [3:0]      digit_zero;
    logic            cnt_is_zero;
    logic            dec_is_zero;

    assign din = {d3, d2, d1, d0};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign din_clamped[gi] = (din[gi] > 4'd9) ? 4'd9 : din[gi];
            assign digit_zero[gi]  = (cnt_reg[gi] == 4'd0);
            assign cnt_dec[gi]     = !borrow[gi]     ? cnt_reg[gi] :
                                     digit_zero[gi] ? 4'd9 :
                                                      4'(cnt_reg[gi] - 4'd1);
        end

        // The units digit always decrements; a higher digit only when every
        // digit below it was 0 and wrapped to 9.
        assign borrow[0] = 1'b1;
        for (gi = 1; gi < 4; gi++) begin : g_borrow
            assign borrow[gi] = borrow[gi-1] & digit_zero[gi-1];
        end
    endgenerate

    assign cnt_is_zero = &digit_zero;
    assign dec_is_zero = (cnt_dec == 16'h0000);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge reloj) begin
        if (reseteador) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            reload_reg  <= '0;
            presc_reg   <= '0;
            alarm_reg   <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            reload_reg  <= reload_next;
            presc_reg   <= presc_next;
            alarm_reg   <= alarm_next;
            running_reg <= running_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: load > stop > start > tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        reload_next = reload_reg;
        presc_next  = presc_reg;
        alarm_next  = alarm_reg;

        if (load) begin
            cnt_next    = din_clamped;
            reload_next = din_clamped;
            presc_next  = '0;
            alarm_next  = 1'b0;
            state_next  = IDLE;
        end else begin
            case (state_reg)
                IDLE, PAUSE: begin
                    // stop is meaningless here, so start is next in line.
                    if (start) begin
                        if (cnt_is_zero) begin
                            state_next = DONE;
                            alarm_next = 1'b1;
                        end else begin
                            state_next = RUN;
                            presc_next = '0;
                        end
                    end
                end

                RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    // A reload alarm is a single-cycle pulse.
                    alarm_next = 1'b0;
`endif
                    if (stop) begin
                        state_next = PAUSE;
                        presc_next = '0;
                    end else if (tick) begin
                        if (presc_reg >= PRESC_LAST) begin
                            presc_next = '0;
                            if (dec_is_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                if (reload_reg != 16'h0000) begin
                                    cnt_next   = reload_reg;
                                    alarm_next = 1'b1;
                                end else begin
                                    cnt_next   = '0;
                                    state_next = DONE;
                                    alarm_next = 1'b1;
                                end
`else
                                cnt_next   = '0;
                                state_next = DONE;
                                alarm_next = 1'b1;
`endif
                            end else begin
                                cnt_next = cnt_dec;
                            end
                        end else begin
                            presc_next = presc_reg + 8'd1;
                        end
                    end
                end

                DONE: begin
                    // Count holds 0000; start and tick are ignored.
                    if (ack) begin
                        alarm_next = 1'b0;
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign running_next = (state_next == RUN);

    assign b0      = cnt_reg[0];
    assign b1      = cnt_reg[1];
    assign b2      = cnt_reg[2];
    assign b3      = cnt_reg[3];
    assign running = running_reg;
    assign alarm   = alarm_reg;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD countdown timer for the alarm-clock design, counting from a loaded value 9999–0000 down to 0000. It is the down-counting counterpart of the 0000–9999 up counter: it is loaded from set-time digits, decrements on a strobe, and raises an alarm at zero. It sits between the time-setting logic (which supplies digits and start/stop) and the display/buzzer logic (which consumes `b0..b3` and `alarm`).

## Interface
- `PRESCALE`, default 1: number of accepted `tick` strobes per decrement; legal range 1–255.

- `reloj` in 1: system clock; all state changes on the rising edge.
- `reseteador` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle count strobe; only counted in RUN.
- `load` in 1: capture `d0..d3` as the new count.
- `d0` in 4: BCD units to load.
- `d1` in 4: BCD tens to load.
- `d2` in 4: BCD hundreds to load.
- `d3` in 4: BCD thousands to load.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `ack` in 1: acknowledge and clear the alarm.
- `b0` out 4: current count, units.
- `b1` out 4: current count, tens.
- `b2` out 4: current count, hundreds.
- `b3` out 4: current count, thousands.
- `running` out 1: high while in RUN.
- `alarm` out 1: zero-reached indication.

## Operation
- State machine states: IDLE, RUN, PAUSE, DONE.
- Reset values:
  - `b0..b3` = 0000.
  - Reload register = 0000.
  - Prescale counter = 0.
  - `alarm` = 0, `running` = 0.
  - State = IDLE.
- Input priority within a cycle, highest first: `reseteador`, `load`, `stop`, `start`, `tick`.
- `load`, in any state:
  - Each digit > 9 is clamped to 9.
  - The clamped value is written to both `b0..b3` and the reload register.
  - Prescale counter cleared, `alarm` cleared, state goes to IDLE.
- `start`:
  - From IDLE or PAUSE, with count ≠ 0000: go to RUN and clear the prescale counter.
  - From IDLE or PAUSE, with count = 0000: go to DONE and set `alarm`.
  - Ignored in RUN and DONE.
- `stop`:
  - In RUN: go to PAUSE and clear the prescale counter. Count holds.
  - Ignored in other states.
- `tick` in RUN:
  - Increments the prescale counter.
  - On the `PRESCALE`-th tick, the counter clears and the count decrements by one.
- BCD decrement rules:
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Otherwise the digit decrements by 1.
  - All digits stay in 0–9 at all times.
- When a decrement produces 0000: state goes to DONE and `alarm` is set on the same edge.
- In DONE:
  - `b0..b3` hold 0000.
  - `alarm` stays high until `ack` or `load`.
  - `ack` clears `alarm` and goes to IDLE.
  - `start` and `tick` are ignored.
- `ack` outside DONE has no effect.
- `running` = (state == RUN), registered.

## Timing
- All outputs are registered.
- A decrement is visible on `b0..b3` the cycle after the accepted strobe's edge, i.e. 1-cycle latency.
- `alarm` rises on the same edge on which `b0..b3` become 0000.
- `load` takes effect in 1 cycle and overrides a simultaneous `tick`, `start`, `stop` or `ack`.
- `stop` together with `tick` in the same cycle: no decrement, go to PAUSE.
- `start` together with `tick` in IDLE: go to RUN, but this tick is not counted.
- `reseteador` asserted mid-count returns all outputs to reset values on the next edge, regardless of other inputs.
- Back-to-back `tick` on consecutive cycles is legal. With `PRESCALE` = 1 this gives one decrement per cycle.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On reaching zero in RUN with a non-zero reload register, `b0..b3` load the reload register instead of 0000.
  - State stays RUN and `alarm` pulses high for exactly one cycle.
  - `ack` is unused.
  - With a reload register of 0000, behaviour is as when the macro is not defined.
- `COUNTDOWN_AUTO_RELOAD_EN` not defined: a single-shot countdown that stops in DONE with `alarm` latched, as described in Operation.

## Test plan
- Reset, then `load` 0003, `start`, 3 ticks (`PRESCALE` = 1): `b` = 0002, 0001, 0000; `alarm` = 1 with `b` = 0000; `running` = 0; `ack` gives `alarm` = 0 and IDLE.
- `load` 1000, `start`, 1 tick: `b` = 0999 (full borrow chain). `load` 0000, `start`: DONE with `alarm` = 1 the next cycle.
- `load` with `d3..d0` = F,A,5,C: `b3..b0` = 9,9,5,9.
- `PRESCALE` = 3, `load` 0002, `start`, 5 ticks: `b` = 0001 after tick 3. `stop` together with tick 6: `b` stays 0001 in PAUSE; `start` plus 3 ticks gives 0000 with `alarm`.
- During RUN with `b` = 0500, assert `reseteador` together with `load`: `b` = 0000, `alarm` = 0, `running` = 0.
- With `COUNTDOWN_AUTO_RELOAD_EN` defined, `load` 0002, `start`, 4 ticks: `b` = 0001, then 0002 with a one-cycle `alarm` pulse, then 0001, then 0002 with another pulse; `running` stays 1 throughout.
